// File: rtl/boot_sequencer.sv
// Boot sequencer: loads framed byte streams into the core's memories, then runs the core under reset/timeout control.
// Optional BOOT_CHECKSUM_EN adds an XOR trailer byte after each load frame's data.
module boot_sequencer #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_MEM    = 3,
  parameter int RST_HOLD   = 2,
  parameter int RUN_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               halt,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic               core_rst,
  output logic               run_done,
  output logic               timeout,
  output logic [31:0]        cycle_cnt,
  output logic               err
);

  localparam int BYTES  = XLEN / 8;
  localparam int BI_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR, S_CNT0, S_CNT1, S_DATA, S_CSUM, S_HOLD, S_RUN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR, S_CNT0, S_CNT1, S_DATA, S_HOLD, S_RUN
  } state_t;
`endif

  state_t              r_state;
  state_t              w_stateNext;
  logic [6:0]          r_target;
  logic [7:0]          r_cntLo;
  logic [15:0]         r_wordsLeft;
  logic [ADDR_W-1:0]   r_wordIdx;
  logic [BI_W-1:0]     r_byteIdx;
  logic [XLEN-1:0]     r_shift;
  logic [7:0]          r_csum;
  logic [HOLD_W-1:0]   r_holdCnt;
  logic [NUM_MEM-1:0]  r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [XLEN-1:0]     r_memWdata;
  logic                r_coreRst;
  logic                r_runDone;
  logic                r_timeout;
  logic [31:0]         r_cycleCnt;
  logic                r_err;

  logic                w_readyState;
  logic                w_accept;
  logic                w_lastByte;
  logic                w_lastWord;
  logic                w_tgtValid;
  logic                w_hdrTgtValid;
  logic                w_holdDone;
  logic                w_runExit;
  logic [15:0]         w_count;
  logic [31:0]         w_cntNext;
  logic [XLEN-1:0]     w_wordNext;
  logic [NUM_MEM-1:0]  w_weOneHot;

  always_comb begin
    w_readyState = 1'b0;
    case (r_state)
      S_HDR, S_CNT0, S_CNT1, S_DATA: w_readyState = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      S_CSUM:                        w_readyState = 1'b1;
`endif
      default:                       w_readyState = 1'b0;
    endcase
  end

  // Gating with rst keeps the link stalled for the whole reset pulse, not just after it.
  assign in_ready      = w_readyState & rst;
  assign w_accept      = in_valid & in_ready;
  assign w_lastByte    = (r_byteIdx == BI_W'(BYTES - 1));
  assign w_lastWord    = (r_wordsLeft == 16'd1);
  assign w_tgtValid    = (int'(r_target) < NUM_MEM);
  assign w_hdrTgtValid = (int'(in_data[6:0]) < NUM_MEM);
  assign w_holdDone    = (r_holdCnt == HOLD_W'(RST_HOLD - 1));
  assign w_cntNext     = r_cycleCnt + 32'd1;
  assign w_runExit     = (r_state == S_RUN) && (halt || (w_cntNext == 32'(RUN_CYCLES)));
  assign w_count       = {in_data, r_cntLo};
  // Little-endian assembly: each new byte enters at the top and earlier bytes slide down.
  assign w_wordNext    = XLEN'({in_data, r_shift} >> 8);
  assign w_weOneHot    = NUM_MEM'(1) << r_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HDR;
    else      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_HDR: begin
        if (w_accept) w_stateNext = in_data[7] ? S_HOLD : S_CNT0;
      end
      S_CNT0: begin
        if (w_accept) w_stateNext = S_CNT1;
      end
      S_CNT1: begin
        if (w_accept) begin
          if (w_count != 16'd0) w_stateNext = S_DATA;
`ifdef BOOT_CHECKSUM_EN
          else                  w_stateNext = S_CSUM;
`else
          else                  w_stateNext = S_HDR;
`endif
        end
      end
      S_DATA: begin
        if (w_accept && w_lastByte && w_lastWord) begin
`ifdef BOOT_CHECKSUM_EN
          w_stateNext = S_CSUM;
`else
          w_stateNext = S_HDR;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) w_stateNext = S_HDR;
      end
`endif
      S_HOLD: begin
        if (w_holdDone) w_stateNext = S_RUN;
      end
      S_RUN: begin
        if (w_runExit) w_stateNext = S_HDR;
      end
      default: w_stateNext = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target    <= '0;
      r_cntLo     <= '0;
      r_wordsLeft <= '0;
      r_wordIdx   <= '0;
      r_byteIdx   <= '0;
      r_shift     <= '0;
      r_csum      <= '0;
      r_holdCnt   <= '0;
      r_memWe     <= '0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_coreRst   <= 1'b1;
      r_runDone   <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycleCnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_memWe <= '0;
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            if (in_data[7]) begin
              r_runDone  <= 1'b0;
              r_timeout  <= 1'b0;
              r_cycleCnt <= '0;
              r_holdCnt  <= '0;
            end else begin
              r_target <= in_data[6:0];
              if (!w_hdrTgtValid) r_err <= 1'b1;
            end
          end
        end
        S_CNT0: begin
          if (w_accept) r_cntLo <= in_data;
        end
        S_CNT1: begin
          if (w_accept) begin
            r_wordsLeft <= w_count;
            r_wordIdx   <= '0;
            r_byteIdx   <= '0;
            r_csum      <= '0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift <= w_wordNext;
            r_csum  <= r_csum ^ in_data;
            if (w_lastByte) begin
              r_byteIdx   <= '0;
              r_wordsLeft <= r_wordsLeft - 16'd1;
              r_wordIdx   <= r_wordIdx + ADDR_W'(1);
              // Frames aimed at a missing target are still consumed, just never written.
              if (w_tgtValid) begin
                r_memWe    <= w_weOneHot;
                r_memAddr  <= r_wordIdx;
                r_memWdata <= w_wordNext;
              end
            end else begin
              r_byteIdx <= r_byteIdx + BI_W'(1);
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept && (in_data != r_csum)) r_err <= 1'b1;
        end
`endif
        S_HOLD: begin
          if (w_holdDone) r_coreRst <= 1'b0;
          else            r_holdCnt <= r_holdCnt + HOLD_W'(1);
        end
        S_RUN: begin
          r_cycleCnt <= w_cntNext;
          // A halt in the same cycle as the limit counts as a clean halt.
          if (w_runExit) begin
            r_coreRst <= 1'b1;
            r_runDone <= 1'b1;
            r_timeout <= ~halt;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign core_rst  = r_coreRst;
  assign run_done  = r_runDone;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cycleCnt;
  assign err       = r_err;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: loads, GO with halt/timeout, bad target, address wrap, mid-word reset.
// Build with BOOT_CHECKSUM_EN defined to also send and test trailer bytes.
module tb_boot_sequencer;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 2;
  localparam int NUM_MEM    = 3;
  localparam int RST_HOLD   = 2;
  localparam int RUN_CYCLES = 500;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               halt;
  logic [NUM_MEM-1:0] mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [XLEN-1:0]    mem_wdata;
  logic               core_rst;
  logic               run_done;
  logic               timeout;
  logic [31:0]        cycle_cnt;
  logic               err;

  int vectors     = 0;
  int miscompares = 0;
  int runCycles;

  logic [XLEN-1:0]    wordBuf [0:7];
  logic [NUM_MEM-1:0] weQ   [$];
  logic [ADDR_W-1:0]  addrQ [$];
  logic [XLEN-1:0]    dataQ [$];

  boot_sequencer #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_MEM(NUM_MEM),
    .RST_HOLD(RST_HOLD), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .halt(halt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .run_done(run_done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write strobe is logged mid-cycle so checks can inspect the whole sequence afterwards.
  always @(negedge clk) begin
    if (mem_we != '0) begin
      weQ.push_back(mem_we);
      addrQ.push_back(mem_addr);
      dataQ.push_back(mem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one byte and holds it until accepted, giving up after a bounded wait.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_wait", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic sendLoad(input logic [7:0] hdr, input int n, input logic badCsum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    applyStimulus(hdr);
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < XLEN / 8; k++) begin
        b = wordBuf[i][8*k +: 8];
        x = x ^ b;
        applyStimulus(b);
      end
    end
    x = badCsum ? ~x : x;
`ifdef BOOT_CHECKSUM_EN
    applyStimulus(x);
`endif
  endtask

  task automatic clearLog();
    weQ.delete();
    addrQ.delete();
    dataQ.delete();
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [NUM_MEM-1:0] expWe,
                            input logic [ADDR_W-1:0] expAddr, input logic [XLEN-1:0] expData);
    logic [NUM_MEM-1:0] we;
    logic [ADDR_W-1:0]  ad;
    logic [XLEN-1:0]    da;
    we = (idx < weQ.size())   ? weQ[idx]   : 'x;
    ad = (idx < addrQ.size()) ? addrQ[idx] : 'x;
    da = (idx < dataQ.size()) ? dataQ[idx] : 'x;
    checkOutput({tag, "_we"},   64'(we), 64'(expWe));
    checkOutput({tag, "_addr"}, 64'(ad), 64'(expAddr));
    checkOutput({tag, "_data"}, 64'(da), 64'(expData));
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    halt     = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
    checkOutput("rst_core_rst",  64'(core_rst),  64'd1);
    checkOutput("rst_mem_we",    64'(mem_we),    64'd0);
    checkOutput("rst_mem_addr",  64'(mem_addr),  64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_run_done",  64'(run_done),  64'd0);
    checkOutput("rst_timeout",   64'(timeout),   64'd0);
    checkOutput("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    checkOutput("rst_err",       64'(err),       64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] two-word instruction load");
    clearLog();
    wordBuf[0] = 32'h00000013;
    wordBuf[1] = 32'h00100093;
    sendLoad(8'h00, 2, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("imem_count", 64'(weQ.size()), 64'd2);
    checkWrite("imem_w0", 0, 3'b001, 2'd0, 32'h00000013);
    checkWrite("imem_w1", 1, 3'b001, 2'd1, 32'h00100093);
    checkOutput("imem_err", 64'(err), 64'd0);

    $display("[TB] empty load then GO to timeout");
    clearLog();
    sendLoad(8'h01, 0, 1'b0);
    applyStimulus(8'h80);
    @(negedge clk);
    checkOutput("hold1_core_rst", 64'(core_rst), 64'd1);
    checkOutput("hold1_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    checkOutput("hold2_core_rst", 64'(core_rst), 64'd1);
    @(negedge clk);
    checkOutput("run_core_rst", 64'(core_rst), 64'd0);
    checkOutput("run_in_ready", 64'(in_ready), 64'd0);
    runCycles = 1;
    for (int i = 0; i < 1000 && !run_done; i++) begin
      @(negedge clk);
      if (!core_rst) runCycles++;
    end
    checkOutput("to_run_done",   64'(run_done),  64'd1);
    checkOutput("to_timeout",    64'(timeout),   64'd1);
    checkOutput("to_cycle_cnt",  64'(cycle_cnt), 64'd500);
    checkOutput("to_run_cycles", 64'(runCycles), 64'd500);
    checkOutput("to_core_rst",   64'(core_rst),  64'd1);
    checkOutput("to_in_ready",   64'(in_ready),  64'd1);
    repeat (3) @(negedge clk);
    checkOutput("to_cnt_hold",   64'(cycle_cnt), 64'd500);
    checkOutput("empty_no_we",   64'(weQ.size()), 64'd0);

    $display("[TB] GO with halt at run cycle 37");
    applyStimulus(8'h80);
    @(negedge clk);
    checkOutput("go_clr_run_done",  64'(run_done),  64'd0);
    checkOutput("go_clr_timeout",   64'(timeout),   64'd0);
    checkOutput("go_clr_cycle_cnt", 64'(cycle_cnt), 64'd0);
    for (int i = 0; i < 20 && core_rst; i++) @(negedge clk);
    checkOutput("halt_released", 64'(core_rst), 64'd0);
    repeat (36) @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    @(negedge clk);
    checkOutput("halt_cycle_cnt", 64'(cycle_cnt), 64'd37);
    checkOutput("halt_run_done",  64'(run_done),  64'd1);
    checkOutput("halt_timeout",   64'(timeout),   64'd0);
    checkOutput("halt_core_rst",  64'(core_rst),  64'd1);
    checkOutput("halt_in_ready",  64'(in_ready),  64'd1);

    $display("[TB] bad target then valid frame");
    clearLog();
    wordBuf[0] = 32'hCAFEF00D;
    sendLoad(8'h05, 1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("badtgt_no_we", 64'(weQ.size()), 64'd0);
    checkOutput("badtgt_err",   64'(err),        64'd1);
    wordBuf[0] = 32'hDEADBEEF;
    sendLoad(8'h02, 1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rf_count", 64'(weQ.size()), 64'd1);
    checkWrite("rf_w0", 0, 3'b100, 2'd0, 32'hDEADBEEF);
    checkOutput("err_sticky", 64'(err), 64'd1);

    $display("[TB] address wrap with five words");
    clearLog();
    for (int i = 0; i < 5; i++) wordBuf[i] = 32'hA5000000 + 32'(i * 17);
    sendLoad(8'h01, 5, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("wrap_count", 64'(weQ.size()), 64'd5);
    checkWrite("wrap_w0", 0, 3'b010, 2'd0, 32'hA5000000);
    checkWrite("wrap_w3", 3, 3'b010, 2'd3, 32'hA5000033);
    checkWrite("wrap_w4", 4, 3'b010, 2'd0, 32'hA5000044);

    $display("[TB] reset in the middle of a word");
    clearLog();
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_core_rst", 64'(core_rst), 64'd1);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("midrst_err",      64'(err),      64'd0);
    rst = 1'b1;
    wordBuf[0] = 32'h12345678;
    sendLoad(8'h00, 1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_count", 64'(weQ.size()), 64'd1);
    checkWrite("midrst_w0", 0, 3'b001, 2'd0, 32'h12345678);
    checkOutput("midrst_err_after", 64'(err), 64'd0);

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] wrong checksum trailer");
    clearLog();
    wordBuf[0] = 32'h0BADC0DE;
    sendLoad(8'h01, 1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("csum_err", 64'(err), 64'd1);
    checkWrite("csum_w0", 0, 3'b010, 2'd0, 32'h0BADC0DE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
